// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each byte as an 8N1 UART frame on tx.
// One FIFO pop per frame, issued only while idle.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;
  logic             bit_end;

  assign bit_end = (baud_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  // tx is registered: each state computes the line level for the next bit period
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        baud_d    = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        shreg_d = fifo_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          tx_done_d = 1'b1;
          baud_d    = '0;
          state_d   = S_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two lanes (CLKS_PER_BIT 4 and 2), each with a FIFO model,
// a UART frame receiver and a scoreboard of bytes pushed into the FIFO.
module tb_fifo_uart_tx;

  localparam int N_LANE = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_LANE-1:0] fifo_empty;
  logic [N_LANE-1:0] fifo_rd_en;
  logic [N_LANE-1:0] tx;
  logic [N_LANE-1:0] busy;
  logic [N_LANE-1:0] tx_done;
  logic [7:0]        fifo_data [N_LANE];
  logic [N_LANE-1:0] wr_en = '0;
  logic [7:0]        wr_data [N_LANE];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int frames_seen [N_LANE] = '{default: 0};
  int rd_cnt [N_LANE] = '{default: 0};
  int rd_err [N_LANE] = '{default: 0};
  int done_cnt [N_LANE] = '{default: 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    localparam int unsigned C = (g == 0) ? 4 : 2;
    logic [7:0] mem [4];
    int         wptr = 0;
    int         rptr = 0;
    int         count = 0;
    int         last_rd = -100;
    logic [7:0] exp_q [$];

    fifo_uart_tx #(.CLKS_PER_BIT(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty[g]),
      .fifo_data (fifo_data[g]),
      .fifo_rd_en(fifo_rd_en[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .tx_done   (tx_done[g])
    );

    assign fifo_empty[g] = (count == 0);

    // FIFO model: data_out valid the cycle after rd_en; cleared together with the DUT
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr         <= 0;
        rptr         <= 0;
        count        <= 0;
        fifo_data[g] <= 8'h00;
        exp_q.delete();
      end else begin
        if (fifo_rd_en[g]) begin
          fifo_data[g] <= mem[rptr];
          rptr         <= (rptr + 1) % 4;
        end
        if (wr_en[g]) begin
          mem[wptr] <= wr_data[g];
          wptr      <= (wptr + 1) % 4;
          exp_q.push_back(wr_data[g]);
        end
        count <= count + (wr_en[g] ? 1 : 0) - (fifo_rd_en[g] ? 1 : 0);
      end
    end

    always @(negedge clk) begin
      if (!rst && fifo_rd_en[g]) begin
        rd_cnt[g]++;
        last_rd = cyc;
        if (busy[g] || fifo_empty[g]) rd_err[g]++;
      end
      if (tx_done[g]) done_cnt[g]++;
    end

    // Receiver: samples every cycle of every bit, aborts the frame on reset
    initial begin : rx
      int         start_cyc, frame_rd, rd_at_start, starts, prev_done;
      int         hold_err, busy_err;
      bit         pend_b2b, aborted;
      logic       ref_bit;
      logic [7:0] got;
      logic [7:0] exp_b;
      starts   = 0;
      prev_done = -1;
      pend_b2b = 1'b0;
      ref_bit  = 1'b1;
      forever begin
        @(negedge clk);
        if (rst || tx[g] !== 1'b0) continue;
        start_cyc   = cyc;
        frame_rd    = last_rd;
        rd_at_start = rd_cnt[g];
        starts++;
        aborted  = 1'b0;
        hold_err = 0;
        busy_err = 0;
        got      = 8'h00;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < int'(C); k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (k == 0) ref_bit = tx[g];
            else if (tx[g] !== ref_bit) hold_err++;
            if (busy[g] !== 1'b1) busy_err++;
            if (b >= 1 && b <= 8 && k == 0) got[b-1] = tx[g];
          end
          if (!aborted && b == 9 && ref_bit !== 1'b1) hold_err++;
        end
        if (aborted) begin
          pend_b2b = 1'b0;
          continue;
        end
        check($sformatf("L%0d_start_latency", g), start_cyc - frame_rd, 2);
        check($sformatf("L%0d_rd_per_frame", g), rd_at_start, starts);
        if (pend_b2b) check($sformatf("L%0d_b2b_gap", g), start_cyc - prev_done, 2);
        check($sformatf("L%0d_bit_hold", g), hold_err, 0);
        check($sformatf("L%0d_busy_in_frame", g), busy_err, 0);
        if (exp_q.size() == 0) begin
          check($sformatf("L%0d_unexpected_frame", g), {24'h0, got}, 32'hffff_ffff);
        end else begin
          exp_b = exp_q.pop_front();
          check($sformatf("L%0d_frame_byte", g), {24'h0, got}, {24'h0, exp_b});
        end
        @(negedge clk);
        check($sformatf("L%0d_tx_done", g), {31'h0, tx_done[g]}, 1);
        check($sformatf("L%0d_done_latency", g), cyc - frame_rd, 10 * C + 2);
        prev_done = cyc;
        pend_b2b  = !fifo_empty[g];
        frames_seen[g]++;
      end
    end
  end

  task automatic push(input int d, input logic [7:0] b);
    wr_en[d]   = 1'b1;
    wr_data[d] = b;
    @(negedge clk);
    wr_en[d] = 1'b0;
  endtask

  task automatic wait_frames(input int d, input int target);
    int budget;
    budget = 3000;
    while (frames_seen[d] < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check($sformatf("L%0d_frames", d), frames_seen[d], target);
  endtask

  task automatic wait_rd(input int d);
    int budget;
    budget = 100;
    while (fifo_rd_en[d] !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check($sformatf("L%0d_rd_seen", d), {31'h0, fifo_rd_en[d]}, 1);
  endtask

  initial begin
    int bad_rd, bad_tx, bad_busy;
    wr_data = '{default: 8'h00};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset asserted mid-idle, outputs checked before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_tx", {30'h0, tx}, 32'h3);
    check("rst_busy", {30'h0, busy}, 0);
    check("rst_rd_en", {30'h0, fifo_rd_en}, 0);
    check("rst_tx_done", {30'h0, tx_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single byte
    push(0, 8'hA5);
    wait_frames(0, 1);

    // four queued bytes, back-to-back frames
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    push(0, 8'h81);
    wait_frames(0, 5);
    repeat (5) @(negedge clk);
    check("burst_fifo_empty", {31'h0, fifo_empty[0]}, 1);
    check("burst_tx_idle", {31'h0, tx[0]}, 1);
    check("burst_rd_count", rd_cnt[0], 5);

    // long empty period
    bad_rd = 0;
    bad_tx = 0;
    bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== '0) bad_rd++;
      if (tx !== '1) bad_tx++;
      if (busy !== '0) bad_busy++;
    end
    check("empty_rd_en", bad_rd, 0);
    check("empty_tx", bad_tx, 0);
    check("empty_busy", bad_busy, 0);

    // reset during data bit 3, then a clean frame
    push(0, 8'h3C);
    wait_rd(0);
    repeat (19) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy[0]}, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'h0, tx[0]}, 1);
    check("mid_rst_busy", {31'h0, busy[0]}, 0);
    check("mid_rst_rd_en", {31'h0, fifo_rd_en[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_frames", frames_seen[0], 5);
    push(0, 8'hC3);
    wait_frames(0, 6);

    // second byte written while the first frame is in DATA
    push(0, 8'h11);
    wait_rd(0);
    repeat (2 + 4 + 12) @(negedge clk);
    push(0, 8'h22);
    wait_frames(0, 8);

    push(1, 8'h11);
    wait_rd(1);
    repeat (2 + 2 + 6) @(negedge clk);
    push(1, 8'h22);
    wait_frames(1, 2);
    repeat (5) @(negedge clk);

    for (int d = 0; d < N_LANE; d++) begin
      check($sformatf("L%0d_rd_when_busy", d), rd_err[d], 0);
      check($sformatf("L%0d_done_count", d), done_cnt[d], frames_seen[d]);
    end
    check("L1_rd_count", rd_cnt[1], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
